spi_flash_seq: RTL

- Hardware sequencer and arbiter in front of the `spi` master's 8-bit register port.
- Lets an instruction-fetch/boot requester stream bytes from a SPI NOR flash using READ (0x03) plus a 24-bit address, without CPU involvement.
- Shares the `spi` register port with the CPU pass-through path, with ownership locking held for the whole chip-select window.
- Sits between the CPU register decoder/fetch unit and the `spi` instance.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_bus_mux.sv | 34 +++
 rtl/spi_flash_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: register map of the spi master plus ownership and sequencer state types
package spi_pkg;
    localparam logic [2:0] SPI_A_START = 3'd0;
    localparam logic [2:0] SPI_A_DATA  = 3'd1;
    localparam logic [2:0] SPI_A_READY = 3'd2;
    localparam logic [2:0] SPI_A_INT   = 3'd3;
    localparam logic [2:0] SPI_A_CFG   = 3'd4;
    typedef enum logic [1:0] {OWN_FREE, OWN_CPU, OWN_SEQ} owner_t;
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_CMD, S_W_CMD, S_A2, S_W_A2, S_A1, S_W_A1,
        S_A0, S_W_A0, S_DATA, S_W_DATA, S_FETCH, S_OUT
    } state_t;
endpackage

// File: rtl/spi_bus_mux.sv
// spi_bus_mux: steers the spi register port to the CPU or the sequencer and stalls the CPU while locked out
module spi_bus_mux
    import spi_pkg::*;
(
    input  owner_t      owner,
    input  logic [2:0]  cpu_addr,
    input  logic [1:0]  cpu_sel,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    input  logic [2:0]  seq_addr,
    input  logic [1:0]  seq_sel,
    input  logic [7:0]  seq_wdata,
    input  logic        seq_read,
    input  logic        seq_write,
    output logic [2:0]  spi_addr,
    output logic [1:0]  spi_sel,
    output logic [7:0]  spi_wdata,
    output logic        spi_read,
    output logic        spi_write,
    input  logic [7:0]  spi_rdata
);
    logic seq_own;
    assign seq_own   = owner == OWN_SEQ;
    assign spi_addr  = seq_own ? seq_addr  : cpu_addr;
    assign spi_sel   = seq_own ? seq_sel   : cpu_sel;
    assign spi_wdata = seq_own ? seq_wdata : cpu_wdata;
    assign spi_read  = seq_own ? seq_read  : cpu_read;
    assign spi_write = seq_own ? seq_write : cpu_write;
    assign cpu_stall = seq_own & (cpu_read | cpu_write);
    assign cpu_rdata = (!seq_own && cpu_read) ? spi_rdata : 8'h00;
endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: streams bytes from SPI NOR flash via READ + 24-bit address, sharing the spi port with the CPU
module spi_flash_seq
    import spi_pkg::*;
#(
    parameter logic [1:0] CS_SEL   = 2'd0,
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter logic [7:0] SPI_CFG  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        ack,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    input  logic        rd_ready,
    output logic        busy,
    input  logic [2:0]  cpu_addr,
    input  logic [1:0]  cpu_sel,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [2:0]  spi_addr,
    output logic [1:0]  spi_sel,
    output logic [7:0]  spi_wdata,
    output logic        spi_read,
    output logic        spi_write,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_int
);
    state_t      state, state_n;
    owner_t      owner, owner_n;
    logic [23:0] addr_q;
    logic [7:0]  cnt, data_q, seq_wdata;
    logic [2:0]  seq_addr;
    logic        last_q, seq_read, seq_write, cpu_a0;
    assign cpu_a0  = (cpu_read | cpu_write) && cpu_addr == SPI_A_START;
    assign busy    = owner == OWN_SEQ;
    assign rd_data = data_q;
    assign rd_last = rd_valid & last_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            owner  <= OWN_FREE;
            addr_q <= 24'h0;
            cnt    <= 8'h0;
            data_q <= 8'h0;
            last_q <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            if (ack) begin
                addr_q <= req_addr;
                cnt    <= req_len;
            end
            if (state == S_FETCH) begin
                data_q <= spi_rdata;
                last_q <= cnt == 8'h0;
            end
            if (state == S_OUT && rd_ready && !last_q)
                cnt <= cnt - 8'd1;
        end
    end
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ack       = 1'b0;
        rd_valid  = 1'b0;
        seq_addr  = SPI_A_DATA;
        seq_wdata = 8'h00;
        seq_read  = 1'b0;
        seq_write = 1'b0;
        // CPU holds the port from its addr0 write until its addr0 read
        if (owner != OWN_SEQ && cpu_write && cpu_addr == SPI_A_START)
            owner_n = OWN_CPU;
        else if (owner == OWN_CPU && cpu_read && cpu_addr == SPI_A_START)
            owner_n = OWN_FREE;
        case (state)
            S_IDLE: if (req && owner == OWN_FREE && !cpu_a0) begin
                ack     = 1'b1;
                owner_n = OWN_SEQ;
                state_n = S_CFG;
            end
            S_CFG: begin
                seq_write = 1'b1;
                seq_addr  = SPI_A_CFG;
                seq_wdata = SPI_CFG;
                state_n   = S_CMD;
            end
            S_CMD: begin
                seq_write = 1'b1;
                seq_addr  = SPI_A_START;
                seq_wdata = CMD_READ;
                state_n   = S_W_CMD;
            end
            S_A2: begin
                seq_write = 1'b1;
                seq_wdata = addr_q[23:16];
                state_n   = S_W_A2;
            end
            S_A1: begin
                seq_write = 1'b1;
                seq_wdata = addr_q[15:8];
                state_n   = S_W_A1;
            end
            S_A0: begin
                seq_write = 1'b1;
                seq_wdata = addr_q[7:0];
                state_n   = S_W_A0;
            end
            S_DATA: begin
                seq_write = 1'b1;
                state_n   = S_W_DATA;
            end
            S_W_CMD:  state_n = spi_int ? S_A2    : state;
            S_W_A2:   state_n = spi_int ? S_A1    : state;
            S_W_A1:   state_n = spi_int ? S_A0    : state;
            S_W_A0:   state_n = spi_int ? S_DATA  : state;
            S_W_DATA: state_n = spi_int ? S_FETCH : state;
            // the final byte is read through addr0 so CS drops with it
            S_FETCH: begin
                seq_read = 1'b1;
                seq_addr = cnt == 8'h0 ? SPI_A_START : SPI_A_DATA;
                state_n  = S_OUT;
            end
            S_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    state_n = last_q ? S_IDLE : S_DATA;
                    owner_n = last_q ? OWN_FREE : owner;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
    spi_bus_mux u_mux (
        .owner(owner),
        .cpu_addr(cpu_addr),
        .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read),
        .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .seq_addr(seq_addr),
        .seq_sel(CS_SEL),
        .seq_wdata(seq_wdata),
        .seq_read(seq_read),
        .seq_write(seq_write),
        .spi_addr(spi_addr),
        .spi_sel(spi_sel),
        .spi_wdata(spi_wdata),
        .spi_read(spi_read),
        .spi_write(spi_write),
        .spi_rdata(spi_rdata)
    );
endmodule
